// File: rtl/vp_update_sched_if.sv
// rtl/vp_update_sched_if.sv - feedback-lane and table-update handshake bundle for vp_update_sched
interface vp_update_sched_if #(
  parameter int P_NUM_PRED    = 2,
  parameter int P_INDEX_WIDTH = 11
);
  logic [P_NUM_PRED-1:0][31:0] fb_pc_i;
  logic [P_NUM_PRED-1:0][31:0] fb_actual_i;
  logic [P_NUM_PRED-1:0]       fb_mispredict_i;
  logic [P_NUM_PRED-1:0]       fb_conf_i;
  logic [P_NUM_PRED-1:0]       fb_valid_i;
  logic                        fb_ready_o;

  logic                        upd_valid_o;
  logic                        upd_ready_i;
  logic                        upd_clear_o;
  logic [P_INDEX_WIDTH-1:0]    upd_index_o;
  logic [31:0]                 upd_pc_o;
  logic [31:0]                 upd_value_o;
  logic                        upd_mispredict_o;
  logic                        upd_conf_o;

  // Scheduler side: consumes feedback lanes, produces table writes.
  modport slave (
    input  fb_pc_i, fb_actual_i, fb_mispredict_i, fb_conf_i, fb_valid_i,
    output fb_ready_o,
    output upd_valid_o, upd_clear_o, upd_index_o, upd_pc_o, upd_value_o,
    output upd_mispredict_o, upd_conf_o,
    input  upd_ready_i
  );

  // Environment side: feedback producer and predictor table.
  modport master (
    output fb_pc_i, fb_actual_i, fb_mispredict_i, fb_conf_i, fb_valid_i,
    input  fb_ready_o,
    input  upd_valid_o, upd_clear_o, upd_index_o, upd_pc_o, upd_value_o,
    input  upd_mispredict_o, upd_conf_o,
    output upd_ready_i
  );
endinterface

// File: rtl/vp_update_sched.sv
// rtl/vp_update_sched.sv - value-predictor table update scheduler (init sweep + update queue); optional VP_UPD_COALESCE_EN
module vp_update_sched #(
  parameter int P_NUM_PRED    = 2,
  parameter int P_FIFO_DEPTH  = 8,
  parameter int P_INDEX_WIDTH = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  vp_update_sched_if.slave    bus,
  output logic                busy_o
);

  localparam int AW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(P_FIFO_DEPTH + 1);
  localparam logic [P_INDEX_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                   state_q, state_d;
  logic [P_INDEX_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;

  logic [31:0] mem_pc    [P_FIFO_DEPTH];
  logic [31:0] mem_value [P_FIFO_DEPTH];
  logic        mem_mis   [P_FIFO_DEPTH];
  logic        mem_conf  [P_FIFO_DEPTH];

  logic [P_NUM_PRED-1:0] lane_keep;
  logic [P_NUM_PRED-1:0] lane_en;
  logic [AW-1:0]         lane_slot [P_NUM_PRED];
  logic [CW-1:0]         enq_cnt;
  logic [CW-1:0]         free_slots;
  logic                  fb_ready;
  logic                  deq;

  // Readiness depends only on registered state, never on this cycle's handshakes.
  assign free_slots     = CW'(P_FIFO_DEPTH) - count_q;
  assign fb_ready       = (state_q == ST_RUN) && (free_slots >= CW'(P_NUM_PRED));
  assign bus.fb_ready_o = fb_ready;

  always_comb begin
    lane_keep = bus.fb_valid_i;
`ifdef VP_UPD_COALESCE_EN
    // A later lane hitting the same table entry supersedes earlier ones.
    for (int i = 0; i < P_NUM_PRED; i++) begin
      for (int j = i + 1; j < P_NUM_PRED; j++) begin
        if (bus.fb_valid_i[j] &&
            (bus.fb_pc_i[j][P_INDEX_WIDTH+1:2] == bus.fb_pc_i[i][P_INDEX_WIDTH+1:2])) begin
          lane_keep[i] = 1'b0;
        end
      end
    end
`endif
  end

  // Kept lanes are packed into consecutive slots in ascending lane order.
  always_comb begin
    lane_en = lane_keep & {P_NUM_PRED{fb_ready && !flush_i}};
    enq_cnt = '0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      lane_slot[i] = wr_ptr_q + enq_cnt[AW-1:0];
      if (lane_en[i]) begin
        enq_cnt = enq_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    init_idx_d           = init_idx_q;
    rd_ptr_d             = rd_ptr_q;
    wr_ptr_d             = wr_ptr_q;
    count_d              = count_q;
    deq                  = 1'b0;
    busy_o               = 1'b1;
    bus.upd_valid_o      = 1'b0;
    bus.upd_clear_o      = 1'b0;
    bus.upd_index_o      = '0;
    bus.upd_pc_o         = '0;
    bus.upd_value_o      = '0;
    bus.upd_mispredict_o = 1'b0;
    bus.upd_conf_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_INIT;
        init_idx_d = '0;
      end

      ST_INIT: begin
        bus.upd_valid_o = 1'b1;
        bus.upd_clear_o = 1'b1;
        bus.upd_index_o = init_idx_q;
        if (flush_i) begin
          init_idx_d = '0;
        end else if (bus.upd_ready_i) begin
          init_idx_d = init_idx_q + P_INDEX_WIDTH'(1);
          if (init_idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        busy_o               = 1'b0;
        bus.upd_valid_o      = (count_q != '0);
        bus.upd_index_o      = mem_pc[rd_ptr_q][P_INDEX_WIDTH+1:2];
        bus.upd_pc_o         = mem_pc[rd_ptr_q];
        bus.upd_value_o      = mem_value[rd_ptr_q];
        bus.upd_mispredict_o = mem_mis[rd_ptr_q];
        bus.upd_conf_o       = mem_conf[rd_ptr_q];
        if (flush_i) begin
          state_d    = ST_INIT;
          init_idx_d = '0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          count_d    = '0;
        end else begin
          deq      = (count_q != '0) && bus.upd_ready_i;
          rd_ptr_d = rd_ptr_q + AW'(deq);
          wr_ptr_d = wr_ptr_q + enq_cnt[AW-1:0];
          count_d  = count_q + enq_cnt - CW'(deq);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      init_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: count/pointers define which slots are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      if (lane_en[i] && !rst_i) begin
        mem_pc[lane_slot[i]]    <= bus.fb_pc_i[i];
        mem_value[lane_slot[i]] <= bus.fb_actual_i[i];
        mem_mis[lane_slot[i]]   <= bus.fb_mispredict_i[i];
        mem_conf[lane_slot[i]]  <= bus.fb_conf_i[i];
      end
    end
  end

endmodule
